// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_responder
//  Description : Responder end of the CPU data_sram interface. It holds a
//                word-addressed array with byte write enables and returns
//                load data after a programmable number of read wait states.
//  Revision    : 1.0  initial release
// ============================================================================
module data_sram_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        stallreq
);

    localparam int         c_depth = 2 ** DEPTH_LOG2;
    localparam logic [3:0] c_wait  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [DEPTH_LOG2-1:0] w_idx_nxt;
    logic [DEPTH_LOG2-1:0] w_req_idx;
    logic [DEPTH_LOG2-1:0] w_rd_sel;
    logic                  w_accept;
    logic                  w_is_write;
    logic                  w_rd_fire;
    logic [31:0]           w_rd_word;
    logic [31:0]           r_rdata;
    logic                  r_rvalid;
    logic                  w_unused_addr;

    // Upper address bits alias onto the array; the byte offset is dropped.
    assign w_req_idx     = data_sram_addr[DEPTH_LOG2+1:2];
    assign w_unused_addr = ^{data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

    assign w_accept   = data_sram_en && (r_state != ST_WAIT);
    assign w_is_write = |data_sram_we;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rd_fire   = 1'b0;
        w_rd_sel    = r_idx;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    if (w_is_write) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_idx_nxt = w_req_idx;
                        if (c_wait == 4'd0) begin
                            w_state_nxt = ST_RESP;
                            w_rd_fire   = 1'b1;
                            w_rd_sel    = w_req_idx;
                        end else begin
                            w_state_nxt = ST_WAIT;
                            w_cnt_nxt   = c_wait;
                        end
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Requester is frozen here, so request inputs are not looked at.
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_RESP;
                    w_rd_fire   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_idx    <= '0;
            r_rdata  <= 32'd0;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_rvalid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    // One byte-wide array per lane; contents survive reset.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [c_depth];

        always_ff @(posedge clk) begin
            if (w_accept && data_sram_we[g]) begin
                r_mem[w_req_idx] <= data_sram_wdata[8*g +: 8];
            end
        end

        assign w_rd_word[8*g +: 8] = r_mem[w_rd_sel];
    end

    assign data_sram_rdata  = r_rdata;
    assign data_sram_rvalid = r_rvalid;
    assign stallreq         = (r_state == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_sram_responder
//  Description : Directed bench for data_sram_responder with three instances
//                (WAIT_CYCLES 0, 2, 3) and a queue of expected load data.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_sram_responder;

    logic        clk;
    logic        reset;
    logic        en     [3];
    logic [3:0]  we     [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [31:0] rdata  [3];
    logic        rvalid [3];
    logic        stall  [3];

    int          wc [3] = '{0, 2, 3};
    logic [31:0] mdl [3][1024];
    logic [31:0] q [$];
    int          checks = 0;
    int          errors = 0;

    data_sram_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset),
        .data_sram_en(en[0]), .data_sram_we(we[0]), .data_sram_addr(addr[0]),
        .data_sram_wdata(wdata[0]), .data_sram_rdata(rdata[0]),
        .data_sram_rvalid(rvalid[0]), .stallreq(stall[0])
    );
    data_sram_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(reset),
        .data_sram_en(en[1]), .data_sram_we(we[1]), .data_sram_addr(addr[1]),
        .data_sram_wdata(wdata[1]), .data_sram_rdata(rdata[1]),
        .data_sram_rvalid(rvalid[1]), .stallreq(stall[1])
    );
    data_sram_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset),
        .data_sram_en(en[2]), .data_sram_we(we[2]), .data_sram_addr(addr[2]),
        .data_sram_wdata(wdata[2]), .data_sram_rdata(rdata[2]),
        .data_sram_rvalid(rvalid[2]), .stallreq(stall[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the write edge.
    task automatic do_write(input int k, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] d);
        en[k] = 1'b1; we[k] = be; addr[k] = a; wdata[k] = d;
        for (int i = 0; i < 4; i++)
            if (be[i]) mdl[k][widx(a)][8*i +: 8] = d[8*i +: 8];
        @(negedge clk);
        check("wr_rvalid", 32'(rvalid[k]), 32'd0);
        check("wr_stall", 32'(stall[k]), 32'd0);
        en[k] = 1'b0; we[k] = 4'h0;
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        check("idle_rvalid", 32'(rvalid[k]), 32'd0);
        check("idle_stall", 32'(stall[k]), 32'd0);
    endtask

    // Issues n back-to-back reads; scr drives garbage writes while stalled.
    task automatic read_seq(input int k, input logic [31:0] a0, input logic [31:0] a1,
                            input int n, input bit scr);
        logic [31:0] a [2];
        logic [31:0] exp;
        int issued, done, stalls, lat, cycles;
        a[0] = a0; a[1] = a1;
        issued = 1; done = 0; stalls = 0; lat = 0; cycles = 0;
        en[k] = 1'b1; we[k] = 4'h0; addr[k] = a[0]; wdata[k] = $urandom;
        q.push_back(mdl[k][widx(a[0])]);
        while (done < n && cycles < 50) begin
            @(negedge clk);
            cycles++; lat++;
            if (stall[k]) begin
                stalls++;
                if (scr) begin
                    en[k] = 1'b1; we[k] = 4'hF; addr[k] = a[issued-1]; wdata[k] = 32'hDEAD_BEEF;
                end
            end else if (rvalid[k]) begin
                exp = q.pop_front();
                check("rd_data", rdata[k], exp);
                check("rd_latency", 32'(lat), 32'(1 + wc[k]));
                check("rd_stall_cycles", 32'(stalls), 32'(wc[k]));
                done++; lat = 0; stalls = 0;
                if (issued < n) begin
                    en[k] = 1'b1; we[k] = 4'h0; addr[k] = a[issued]; wdata[k] = $urandom;
                    q.push_back(mdl[k][widx(a[issued])]);
                    issued++;
                end else begin
                    en[k] = 1'b0; we[k] = 4'h0;
                end
            end else begin
                check("rd_protocol", 32'(lat), 32'hFFFF_FFFF);
            end
        end
        if (done < n) check("rd_timeout", 32'(done), 32'(n));
        en[k] = 1'b0; we[k] = 4'h0;
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; we[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_rdata", rdata[k], 32'd0);
            check("rst_rvalid", 32'(rvalid[k]), 32'd0);
            check("rst_stall", 32'(stall[k]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Full-word write, then read the next cycle with no wait states.
        do_write(0, 32'h40, 4'hF, 32'h1234_5678);
        read_seq(0, 32'h40, 32'h0, 1, 1'b0);
        idle(0);

        // Byte-enable merge.
        do_write(0, 32'h40, 4'b0101, 32'hAABB_CCDD);
        check("be_model", mdl[0][16], 32'h12BB_56DD);
        read_seq(0, 32'h40, 32'h0, 1, 1'b0);

        // Address aliasing above the array depth.
        do_write(0, 32'h0, 4'hF, 32'h5555_5555);
        do_write(0, 32'h0000_1000, 4'hF, 32'h0000_0001);
        read_seq(0, 32'h0, 32'h0, 1, 1'b0);
        check("alias_model", mdl[0][0], 32'h0000_0001);
        idle(0);

        // Back-to-back reads with two wait states.
        do_write(1, 32'h00, 4'hF, 32'h1111_1111);
        do_write(1, 32'h04, 4'hF, 32'h2222_2222);
        read_seq(1, 32'h00, 32'h04, 2, 1'b0);
        idle(1);

        // Three wait states with inputs scrambled during the wait.
        do_write(2, 32'h80, 4'hF, 32'hCAFE_F00D);
        read_seq(2, 32'h80, 32'h0, 1, 1'b1);
        idle(2);

        // Reset in the middle of a wait aborts the read immediately.
        en[2] = 1'b1; we[2] = 4'h0; addr[2] = 32'h80;
        @(negedge clk);
        check("pre_rst_stall", 32'(stall[2]), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_stall", 32'(stall[2]), 32'd0);
        check("mid_rst_rdata", rdata[2], 32'd0);
        check("mid_rst_rvalid", 32'(rvalid[2]), 32'd0);
        en[2] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        read_seq(2, 32'h80, 32'h0, 1, 1'b0);
        read_seq(0, 32'h40, 32'h0, 1, 1'b0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
